// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter shared by video scan-out and the CPU.
// Handshake: a requester holds req with stable addr/data until ack; every
// cycle with req=1 and ack=1 is exactly one transaction, so holding req after
// ack starts a new one. Read data returns RD_LATENCY cycles after the ack and
// is flagged by the owner's rvalid.
// Video normally wins. The CPU is guaranteed a slot once it has watched
// STARVE_LIMIT consecutive video grants while waiting.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_forced
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Starvation counter and the forced-grant flag.
  logic [7:0] starve_q, starve_d;
  logic       forced_q, forced_d;

  // Read-tracking pipeline: stage 0 is loaded on the ack cycle, so the last
  // stage lines up with ram_rdata. own = 1 marks a CPU read.
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [RD_LATENCY-1:0] own_q, own_d;

  logic force_cpu;
  logic vid_gnt;
  logic cpu_gnt;
  logic rd_issue;

  // Grant decision: nothing is granted while reset is held.
  always_comb begin
    force_cpu = vid_req & cpu_req & (starve_q == LIMIT);
    vid_gnt   = ~reset & vid_req & ~force_cpu;
    cpu_gnt   = ~reset & cpu_req & (~vid_req | force_cpu);
    rd_issue  = vid_gnt | (cpu_gnt & ~cpu_we);
  end

  // Next-state for the starvation counter and the forced-grant pulse.
  always_comb begin
    starve_d = starve_q;
    forced_d = cpu_gnt & force_cpu;
    if (cpu_gnt || !cpu_req) begin
      starve_d = '0;
    end else if (vid_gnt && (starve_q != LIMIT)) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Next-state for the read-tracking shift register.
  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = rd_issue;
    own_d[0] = cpu_gnt;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  // State registers; reset discards every read in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
      forced_q <= 1'b0;
      vld_q    <= '0;
      own_q    <= '0;
    end else begin
      starve_q <= starve_d;
      forced_q <= forced_d;
      vld_q    <= vld_d;
      own_q    <= own_d;
    end
  end

  // RAM strobes and response routing.
  always_comb begin
    vid_ack    = vid_gnt;
    cpu_ack    = cpu_gnt;
    ram_en     = vid_gnt | cpu_gnt;
    ram_we     = cpu_gnt & cpu_we;
    ram_addr   = vid_gnt ? vid_addr : cpu_addr;
    ram_wdata  = cpu_wdata;
    vid_rdata  = ram_rdata;
    cpu_rdata  = ram_rdata;
    vid_rvalid = ~reset & vld_q[RD_LATENCY-1] & ~own_q[RD_LATENCY-1];
    cpu_rvalid = ~reset & vld_q[RD_LATENCY-1] &  own_q[RD_LATENCY-1];
    cpu_forced = forced_q;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with default parameters
// (RD_LATENCY=2, STARVE_LIMIT=7). Inputs change 1 ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_vram_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_ack;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          cpu_forced;

  int total = 0;
  int bad = 0;

  vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_ack    (vid_ack),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .cpu_forced (cpu_forced)
  );

  // Clock and a hard time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Start a new cycle: inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_reset();
    // Two cycles of reset with both requests high: everything stays quiet.
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      reset = 1'b1; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
      sample();
      total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL rst_vid_ack got=%b exp=0", vid_ack); end
      total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL rst_cpu_ack got=%b exp=0", cpu_ack); end
      total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL rst_ram_en got=%b exp=0", ram_en); end
      total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL rst_ram_we got=%b exp=0", ram_we); end
      total++; if ({vid_rvalid, cpu_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid got=%b exp=00", {vid_rvalid, cpu_rvalid}); end
      total++; if (cpu_forced !== 1'b0) begin bad++; $display("FAIL rst_forced got=%b exp=0", cpu_forced); end
    end
    // First cycle out of reset: a CPU write is granted at once.
    next_cycle();
    reset = 1'b0; vid_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 16'h0001; cpu_wdata = 16'h0002;
    sample();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL first_grant got=%b exp=1", cpu_ack); end
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 3; c++) next_cycle();
  endtask

  task automatic test_vid_read();
    next_cycle();
    vid_req = 1'b1; vid_addr = 16'h0040;
    sample();
    total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL vr_ack got=%b exp=1", vid_ack); end
    total++; if (cpu_ack !== 1'b0) begin bad++; $display("FAIL vr_cpu_ack got=%b exp=0", cpu_ack); end
    total++; if ({ram_en, ram_we} !== 2'b10) begin bad++; $display("FAIL vr_strobes got=%b exp=10", {ram_en, ram_we}); end
    total++; if (ram_addr !== 16'h0040) begin bad++; $display("FAIL vr_addr got=%h exp=0040", ram_addr); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL vr_cpu_rv0 got=%b exp=0", cpu_rvalid); end
    next_cycle();
    vid_req = 1'b0;
    sample();
    total++; if (ram_en !== 1'b0) begin bad++; $display("FAIL vr_idle_en got=%b exp=0", ram_en); end
    total++; if (vid_rvalid !== 1'b0) begin bad++; $display("FAIL vr_rv_early got=%b exp=0", vid_rvalid); end
    next_cycle();
    ram_rdata = 16'hBEEF;
    sample();
    total++; if (vid_rvalid !== 1'b1) begin bad++; $display("FAIL vr_rv got=%b exp=1", vid_rvalid); end
    total++; if (vid_rdata !== 16'hBEEF) begin bad++; $display("FAIL vr_data got=%h exp=beef", vid_rdata); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL vr_cpu_rv got=%b exp=0", cpu_rvalid); end
    next_cycle();
    ram_rdata = 16'h0000;
    sample();
    total++; if (vid_rvalid !== 1'b0) begin bad++; $display("FAIL vr_rv_late got=%b exp=0", vid_rvalid); end
  endtask

  task automatic test_cpu_write();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 16'h5A5A;
    sample();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL cw_ack got=%b exp=1", cpu_ack); end
    total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL cw_vid_ack got=%b exp=0", vid_ack); end
    total++; if ({ram_en, ram_we} !== 2'b11) begin bad++; $display("FAIL cw_strobes got=%b exp=11", {ram_en, ram_we}); end
    total++; if (ram_addr !== 16'h1234) begin bad++; $display("FAIL cw_addr got=%h exp=1234", ram_addr); end
    total++; if (ram_wdata !== 16'h5A5A) begin bad++; $display("FAIL cw_wdata got=%h exp=5a5a", ram_wdata); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      idle_inputs();
      sample();
      total++; if ({vid_rvalid, cpu_rvalid} !== 2'b00) begin bad++; $display("FAIL cw_no_rv c=%0d got=%b exp=00", c, {vid_rvalid, cpu_rvalid}); end
      total++; if (cpu_forced !== 1'b0) begin bad++; $display("FAIL cw_forced c=%0d got=%b exp=0", c, cpu_forced); end
    end
  endtask

  task automatic test_cpu_read();
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0777;
    sample();
    total++; if ({cpu_ack, ram_en, ram_we} !== 3'b110) begin bad++; $display("FAIL cr_issue got=%b exp=110", {cpu_ack, ram_en, ram_we}); end
    total++; if (ram_addr !== 16'h0777) begin bad++; $display("FAIL cr_addr got=%h exp=0777", ram_addr); end
    next_cycle();
    idle_inputs();
    next_cycle();
    ram_rdata = 16'hC0DE;
    sample();
    total++; if ({cpu_rvalid, vid_rvalid} !== 2'b10) begin bad++; $display("FAIL cr_rv got=%b exp=10", {cpu_rvalid, vid_rvalid}); end
    total++; if (cpu_rdata !== 16'hC0DE) begin bad++; $display("FAIL cr_data got=%h exp=c0de", cpu_rdata); end
    next_cycle();
    ram_rdata = 16'h0000;
  endtask

  task automatic test_starvation();
    logic exp_cpu;
    logic exp_forced;
    // Both requests held high; CPU writes so only video reads are tracked.
    for (int k = 0; k < 24; k++) begin
      next_cycle();
      vid_req = 1'b1; vid_addr = 16'h0100 + 16'(k);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 16'h00AA;
      sample();
      exp_cpu    = ((k % 8) == 7);
      exp_forced = ((k % 8) == 0) && (k != 0);
      total++; if ({vid_ack, cpu_ack} !== {~exp_cpu, exp_cpu}) begin bad++; $display("FAIL starve_acks k=%0d got=%b exp=%b", k, {vid_ack, cpu_ack}, {~exp_cpu, exp_cpu}); end
      total++; if (ram_we !== exp_cpu) begin bad++; $display("FAIL starve_we k=%0d got=%b exp=%b", k, ram_we, exp_cpu); end
      total++; if (cpu_forced !== exp_forced) begin bad++; $display("FAIL starve_forced k=%0d got=%b exp=%b", k, cpu_forced, exp_forced); end
    end
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 3; c++) next_cycle();
  endtask

  task automatic test_back_to_back();
    // V, C, V acked on consecutive cycles.
    next_cycle();
    vid_req = 1'b1; vid_addr = 16'h0010;
    sample();
    total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL bb_ack0 got=%b exp=1", vid_ack); end
    next_cycle();
    vid_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    sample();
    total++; if (cpu_ack !== 1'b1) begin bad++; $display("FAIL bb_ack1 got=%b exp=1", cpu_ack); end
    next_cycle();
    cpu_req = 1'b0; vid_req = 1'b1; vid_addr = 16'h0030; ram_rdata = 16'h1111;
    sample();
    total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL bb_ack2 got=%b exp=1", vid_ack); end
    total++; if ({vid_rvalid, cpu_rvalid} !== 2'b10) begin bad++; $display("FAIL bb_rv0 got=%b exp=10", {vid_rvalid, cpu_rvalid}); end
    total++; if (vid_rdata !== 16'h1111) begin bad++; $display("FAIL bb_d0 got=%h exp=1111", vid_rdata); end
    next_cycle();
    vid_req = 1'b0; ram_rdata = 16'h2222;
    sample();
    total++; if ({vid_rvalid, cpu_rvalid} !== 2'b01) begin bad++; $display("FAIL bb_rv1 got=%b exp=01", {vid_rvalid, cpu_rvalid}); end
    total++; if (cpu_rdata !== 16'h2222) begin bad++; $display("FAIL bb_d1 got=%h exp=2222", cpu_rdata); end
    next_cycle();
    ram_rdata = 16'h3333;
    sample();
    total++; if ({vid_rvalid, cpu_rvalid} !== 2'b10) begin bad++; $display("FAIL bb_rv2 got=%b exp=10", {vid_rvalid, cpu_rvalid}); end
    total++; if (vid_rdata !== 16'h3333) begin bad++; $display("FAIL bb_d2 got=%h exp=3333", vid_rdata); end
    next_cycle();
    ram_rdata = 16'h0000;
    sample();
    total++; if ({vid_rvalid, cpu_rvalid} !== 2'b00) begin bad++; $display("FAIL bb_rv3 got=%b exp=00", {vid_rvalid, cpu_rvalid}); end
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    vid_req = 1'b1; vid_addr = 16'h0050;
    sample();
    total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL rm_ack got=%b exp=1", vid_ack); end
    // Reset held for two cycles with both requesters pushing.
    for (int c = 1; c <= 2; c++) begin
      next_cycle();
      reset = 1'b1; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
      sample();
      total++; if ({vid_ack, cpu_ack, ram_en, ram_we} !== 4'b0000) begin bad++; $display("FAIL rm_quiet c=%0d got=%b exp=0000", c, {vid_ack, cpu_ack, ram_en, ram_we}); end
      total++; if ({vid_rvalid, cpu_rvalid, cpu_forced} !== 3'b000) begin bad++; $display("FAIL rm_rv c=%0d got=%b exp=000", c, {vid_rvalid, cpu_rvalid, cpu_forced}); end
    end
    for (int c = 3; c <= 5; c++) begin
      next_cycle();
      reset = 1'b0;
      idle_inputs();
      sample();
      total++; if ({vid_rvalid, cpu_rvalid} !== 2'b00) begin bad++; $display("FAIL rm_after c=%0d got=%b exp=00", c, {vid_rvalid, cpu_rvalid}); end
    end
  endtask

  initial begin
    test_reset();
    test_vid_read();
    test_cpu_write();
    test_cpu_read();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
